// File: rtl/three_input_gate_pkg.sv
// Shared constants, state encoding and code-search helper for the
// three-input gate sweep sequencer.
package three_input_gate_pkg;

  localparam int VEC_W       = 5;
  localparam int N_VEC       = 32;
  localparam int CODE_W      = 2;
  localparam int N_CODE      = 4;
  localparam int POS_A       = 0;
  localparam int POS_B       = 1;
  localparam int POS_C       = 2;
  localparam int POS_CODE_LO = 3;
  localparam int POS_CODE_HI = 4;

  typedef logic [VEC_W-1:0] vec_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  typedef struct packed {
    logic              found;
    logic [CODE_W-1:0] code;
  } code_sel_t;

  // Lowest enabled code whose index is >= from; from may be N_CODE (none left).
  function automatic code_sel_t find_code(input logic [N_CODE-1:0] mask,
                                          input logic [CODE_W:0]   from);
    code_sel_t r;
    r = '0;
    for (int i = N_CODE - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) begin
        r.found = 1'b1;
        r.code  = CODE_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/three_input_gate_next_vec_v.sv
// Combinational vector stepper: first enabled vector for a mask, and the
// successor of a vector with a flag marking the final enabled vector.
module three_input_gate_next_vec_v
  import three_input_gate_pkg::*;
(
  input  logic [VEC_W-1:0]  vec,
  input  logic [N_CODE-1:0] mask,
  output logic [VEC_W-1:0]  first_vec,
  output logic              any_en,
  output logic [VEC_W-1:0]  next_vec,
  output logic              last
);

  logic [2:0]        abc;
  logic [CODE_W-1:0] code;
  logic [CODE_W:0]   code_up;
  code_sel_t         lo_sel;
  code_sel_t         up_sel;

  assign abc     = vec[POS_C:POS_A];
  assign code    = vec[POS_CODE_HI:POS_CODE_LO];
  assign code_up = {1'b0, code} + {{CODE_W{1'b0}}, 1'b1};
  assign lo_sel  = find_code(mask, '0);
  assign up_sel  = find_code(mask, code_up);

  assign first_vec = {lo_sel.code, 3'b000};
  assign any_en    = lo_sel.found;

  // abc wrap jumps over whole disabled code groups of 8
  always_comb begin
    last     = 1'b0;
    next_vec = '0;
    if (abc != 3'd7) begin
      next_vec = {code, abc + 3'd1};
    end else if (up_sel.found) begin
      next_vec = {up_sel.code, 3'b000};
    end else begin
      last = 1'b1;
    end
  end

endmodule

// File: rtl/three_input_gate_sweep_ctrl_v.sv
// Sweep sequencer: drives every enabled (code,c,b,a) vector onto the gate,
// holds it SETTLE_CYCLES, samples i_f into o_table, and reports done.
module three_input_gate_sweep_ctrl_v
  import three_input_gate_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [3:0]  i_code_en,
  input  logic        i_f,
  output logic        o_a,
  output logic        o_b,
  output logic        o_c,
  output logic [1:0]  o_code,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_table
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;

  state_t              state_q, state_d;
  vec_t                vec_q, vec_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_CODE-1:0]   mask_q, mask_d, mask_sel;
  logic                tbl_clr, tbl_wr;
  vec_t                first_vec, next_vec;
  logic                any_en, last;
  logic                busy_d, done_d;
  vec_t                pins_d;

  // In IDLE the live enable bits pick the first vector; afterwards the latched copy.
  assign mask_sel = (state_q == ST_IDLE) ? i_code_en : mask_q;

  three_input_gate_next_vec_v u_next (
    .vec       (vec_q),
    .mask      (mask_sel),
    .first_vec (first_vec),
    .any_en    (any_en),
    .next_vec  (next_vec),
    .last      (last)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      o_table <= '0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_a     <= 1'b0;
      o_b     <= 1'b0;
      o_c     <= 1'b0;
      o_code  <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      if (tbl_clr)     o_table        <= '0;
      else if (tbl_wr) o_table[vec_q] <= i_f;
      o_busy  <= busy_d;
      o_done  <= done_d;
      o_a     <= pins_d[POS_A];
      o_b     <= pins_d[POS_B];
      o_c     <= pins_d[POS_C];
      o_code  <= pins_d[POS_CODE_HI:POS_CODE_LO];
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    tbl_clr = 1'b0;
    tbl_wr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          mask_d  = i_code_en;
          tbl_clr = 1'b1;
          cnt_d   = '0;
          if (any_en) begin
            state_d = ST_DRIVE;
            vec_d   = first_vec;
          end else begin
            state_d = ST_DONE;
            vec_d   = '0;
          end
        end
      end
      ST_DRIVE: begin
        if (i_abort) begin
          state_d = ST_IDLE;
          vec_d   = '0;
        end else if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SAMPLE: begin
        // abort wins over the capture of the vector in flight
        if (i_abort) begin
          state_d = ST_IDLE;
          vec_d   = '0;
        end else begin
          tbl_wr = 1'b1;
          cnt_d  = '0;
          if (last) begin
            state_d = ST_DONE;
            vec_d   = '0;
          end else begin
            state_d = ST_DRIVE;
            vec_d   = next_vec;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        vec_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they land in step with it.
  always_comb begin
    busy_d = (state_d == ST_DRIVE) || (state_d == ST_SAMPLE);
    done_d = (state_d == ST_DONE);
    pins_d = busy_d ? vec_d : '0;
  end

endmodule

// File: tb/tb_three_input_gate_sweep_ctrl_v.sv
// Bench for the sweep sequencer: stub gate models, table-driven sweeps,
// randomized masks/truth tables against a simple model, abort and reset cases.
module tb_three_input_gate_sweep_ctrl_v;

  logic        clk, rst_n, i_start, i_abort, i_f;
  logic [3:0]  i_code_en;
  logic        o_a, o_b, o_c, o_busy, o_done;
  logic [1:0]  o_code;
  logic [31:0] o_table;
  logic [4:0]  pins;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          mode  = 0;
  logic [31:0] lut   = '0;

  three_input_gate_sweep_ctrl_v #(.SETTLE_CYCLES(2)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_start   (i_start),
    .i_abort   (i_abort),
    .i_code_en (i_code_en),
    .i_f       (i_f),
    .o_a       (o_a),
    .o_b       (o_b),
    .o_c       (o_c),
    .o_code    (o_code),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_table   (o_table)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign pins = {o_code, o_c, o_b, o_a};

  // Stub gate
  always_comb begin
    case (mode)
      0:       i_f = pins[0];
      1:       i_f = 1'b1;
      2:       i_f = pins[4];
      default: i_f = lut[pins];
    endcase
  end

  typedef struct {
    logic [3:0]  mask;
    int          mode;
    bit          abort_w;
    int          disturb;
    logic [31:0] exp_tbl;
    int          exp_n;
  } rec_t;

  rec_t recs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_table(input logic [3:0] mask, input int md,
                                              input logic [31:0] lt);
    logic [31:0] t;
    logic [4:0]  v5;
    t = '0;
    for (int v = 0; v < 32; v++) begin
      v5 = 5'(v);
      if (mask[v / 8]) begin
        case (md)
          0:       t[v] = v5[0];
          1:       t[v] = 1'b1;
          2:       t[v] = v5[4];
          default: t[v] = lt[v];
        endcase
      end
    end
    return t;
  endfunction

  // Start a sweep and follow it to done; returns table, done latency and pin-sequence errors.
  task automatic run_sweep(input logic [3:0] mask, input int disturb, input bit with_abort,
                           output logic [31:0] tbl, output int n_done, output int seq_err);
    int q[$];
    int exp_q[$];
    for (int v = 0; v < 32; v++)
      if (mask[v / 8]) repeat (3) exp_q.push_back(v);
    @(negedge clk);
    i_start = 1'b1; i_code_en = mask; i_abort = with_abort;
    @(negedge clk);
    i_start = 1'b0; i_abort = 1'b0; i_code_en = ~mask;
    n_done = -1;
    for (int n = 0; n < 1000; n++) begin
      if (n == disturb) begin
        i_start = 1'b1; i_code_en = 4'($urandom);
      end else begin
        i_start = 1'b0;
      end
      if (o_busy) q.push_back(int'(pins));
      if (o_done) begin
        n_done = n;
        break;
      end
      @(negedge clk);
    end
    i_start = 1'b0;
    tbl = o_table;
    seq_err = (q.size() != exp_q.size()) ? 1 : 0;
    if (seq_err == 0)
      foreach (q[i]) if (q[i] != exp_q[i]) seq_err++;
  endtask

  task automatic sweep_and_check(input string tag, input logic [3:0] mask, input int disturb,
                                 input bit with_abort, input logic [31:0] exp_tbl,
                                 input int exp_n);
    logic [31:0] tbl;
    int          n_done, seq_err;
    run_sweep(mask, disturb, with_abort, tbl, n_done, seq_err);
    check({tag, "_table"}, tbl, exp_tbl);
    check({tag, "_done_lat"}, 32'(n_done), 32'(exp_n));
    check({tag, "_pin_seq"}, 32'(seq_err), 32'd0);
    check({tag, "_at_done"}, {30'd0, o_busy, |pins}, 32'd0);
    @(negedge clk);
    check({tag, "_after_done"}, {30'd0, o_done, o_busy}, 32'd0);
    check({tag, "_table_hold"}, o_table, exp_tbl);
  endtask

  task automatic wait_vec(input logic [4:0] target, output bit found);
    found = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (o_busy && pins == target) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    bit          found;
    int          seen;
    logic [3:0]  rmask;
    i_start = 1'b0; i_abort = 1'b0; i_code_en = 4'h0; rst_n = 1'b0;

    recs[0] = '{4'hF, 0, 1'b0, -1, 32'hAAAA_AAAA, 96};
    recs[1] = '{4'h5, 1, 1'b0, -1, 32'h00FF_00FF, 48};
    recs[2] = '{4'h0, 1, 1'b0, -1, 32'h0000_0000, 0};
    recs[3] = '{4'hF, 2, 1'b0, -1, 32'hFFFF_0000, 96};
    recs[4] = '{4'hA, 0, 1'b0, -1, 32'hAA00_AA00, 48};
    recs[5] = '{4'h8, 1, 1'b1, -1, 32'hFF00_0000, 24};
    recs[6] = '{4'h5, 1, 1'b0, 10, 32'h00FF_00FF, 48};

    repeat (3) @(negedge clk);
    check("reset_ctl", {27'd0, o_busy, o_done, o_a, o_b, o_c}, 32'd0);
    check("reset_code_table", o_table | {30'd0, o_code}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_pins", {27'd0, pins}, 32'd0);

    foreach (recs[i]) begin
      mode = recs[i].mode;
      sweep_and_check($sformatf("vec%0d", i), recs[i].mask, recs[i].disturb,
                      recs[i].abort_w, recs[i].exp_tbl, recs[i].exp_n);
    end

    for (int r = 0; r < 6; r++) begin
      mode  = 3;
      lut   = $urandom;
      rmask = 4'($urandom_range(0, 15));
      sweep_and_check($sformatf("rand%0d", r), rmask, -1, 1'b0,
                      model_table(rmask, 3, lut), 24 * $countones(rmask));
    end

    // Abort in the first settle cycle of vector 20
    mode = 2;
    @(negedge clk);
    i_start = 1'b1; i_code_en = 4'hF;
    @(negedge clk);
    i_start = 1'b0;
    wait_vec(5'd20, found);
    check("abort_reach", {31'd0, found}, 32'd1);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    check("abort_ctl", {27'd0, o_busy, o_done, |pins, 2'b00}, 32'd0);
    check("abort_table", o_table, 32'h000F_0000);
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (o_done || o_busy) seen++;
    end
    check("abort_quiet", 32'(seen), 32'd0);

    // Reset pulse during vector 10, then a clean full sweep
    mode = 0;
    @(negedge clk);
    i_start = 1'b1; i_code_en = 4'hF;
    @(negedge clk);
    i_start = 1'b0;
    wait_vec(5'd10, found);
    check("rst_reach", {31'd0, found}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_async_ctl", {27'd0, o_busy, o_done, |pins, 2'b00}, 32'd0);
    check("rst_async_table", o_table, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_no_done", {31'd0, o_done}, 32'd0);
    sweep_and_check("post_rst", 4'hF, -1, 1'b0, 32'hAAAA_AAAA, 96);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
